// File: rtl/fb_scanout.sv
// Raster scan-out stage: generates display timing, prefetches one framebuffer
// word per visible pixel one slot ahead, and drives registered RGB/DE/sync pins.
module fb_scanout #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 320,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 10,
  parameter int PIX_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [16:0] fb_address,
  output logic        fb_rw,
  output logic        fb_en,
  input  logic [23:0] fb_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int PW = $clog2(PIX_DIV);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0] P_LAST = PW'(PIX_DIV - 1);
  localparam logic [PW-1:0] P_CAP  = PW'(2);
  localparam logic [16:0]   A_LAST = 17'(H_ACTIVE * V_ACTIVE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [PW-1:0] r_phase;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [16:0]   r_addr;
  logic          r_fetched;
  logic          r_fb_en;
  logic [23:0]   r_pref;
  logic          r_hsync, r_vsync, r_de, r_frame_start;
  logic [7:0]    r_r, r_g, r_b;

  // w_h1/w_v1: slot about to start; w_h2/w_v2: the slot after it (fetch target)
  logic [HW-1:0] w_h1, w_h2;
  logic [VW-1:0] w_v1, w_v2;
  logic          w_pwrap, w_frame_end, w_de1, w_fetch_nxt;
  logic [23:0]   w_pix;

  assign w_h1 = (r_hcnt == H_LAST) ? '0 : r_hcnt + 1'b1;
  assign w_v1 = (r_hcnt != H_LAST) ? r_vcnt : ((r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1);
  assign w_h2 = (w_h1 == H_LAST) ? '0 : w_h1 + 1'b1;
  assign w_v2 = (w_h1 != H_LAST) ? w_v1 : ((w_v1 == V_LAST) ? '0 : w_v1 + 1'b1);

  assign w_pwrap     = (r_phase == P_LAST);
  assign w_frame_end = w_pwrap && (r_hcnt == H_LAST) && (r_vcnt == V_LAST);
  assign w_de1       = (w_h1 < H_VIS) && (w_v1 < V_VIS);
  assign w_fetch_nxt = (w_h2 < H_VIS) && (w_v2 < V_VIS);
  // With PIX_DIV=3 the capture edge is also the slot edge, so bypass the register
  assign w_pix       = (r_phase == P_CAP && r_fetched) ? fb_data : r_pref;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_addr        <= '0;
      r_fetched     <= 1'b0;
      r_fb_en       <= 1'b0;
      r_pref        <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_RUN;
            r_phase   <= '0;
            r_hcnt    <= H_LAST;
            r_vcnt    <= V_LAST;
            r_addr    <= '0;
            r_fb_en   <= 1'b1;
            r_fetched <= 1'b1;
          end
        end
        S_RUN: begin
          r_frame_start <= 1'b0;
          r_fb_en       <= 1'b0;
          r_phase       <= w_pwrap ? '0 : r_phase + 1'b1;
          if (r_phase == P_CAP && r_fetched)
            r_pref <= fb_data;
          if (w_frame_end && !enable) begin
            r_state   <= S_IDLE;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_addr    <= '0;
            r_fetched <= 1'b0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_de      <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
          end else if (w_pwrap) begin
            r_hcnt        <= w_h1;
            r_vcnt        <= w_v1;
            r_de          <= w_de1;
            r_r           <= w_de1 ? w_pix[7:0]   : 8'd0;
            r_g           <= w_de1 ? w_pix[15:8]  : 8'd0;
            r_b           <= w_de1 ? w_pix[23:16] : 8'd0;
            r_hsync       <= !((w_h1 >= HS_BEG) && (w_h1 < HS_END));
            r_vsync       <= !((w_v1 >= VS_BEG) && (w_v1 < VS_END));
            r_frame_start <= (w_h1 == '0) && (w_v1 == '0);
            r_fb_en       <= w_fetch_nxt;
            r_fetched     <= w_fetch_nxt;
            if (r_fetched)
              r_addr <= (r_addr == A_LAST) ? 17'd0 : r_addr + 17'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fb_address  = r_addr;
  assign fb_rw       = 1'b0;
  assign fb_en       = r_fb_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a tiny 8x6-slot raster (4 clk per slot, 192 clk per frame).
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [16:0] fb_address;
  logic        fb_rw, fb_en;
  logic [23:0] fb_data;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  r, g, b;
  logic [7:0]  ram_a;

  int n_vec = 0;
  int n_bad = 0;

  fb_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_address(fb_address), .fb_rw(fb_rw), .fb_en(fb_en), .fb_data(fb_data),
    .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data for address a is {a+2, a+1, a} one clk after fb_en
  assign ram_a = fb_address[7:0];
  always @(posedge clk)
    if (fb_en) fb_data <= {ram_a + 8'd2, ram_a + 8'd1, ram_a};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, 32'({fb_en, fb_rw, hsync, vsync, de, frame_start}), 32'b001100);
    check({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
    check({tag, "_addr"}, 32'(fb_address), 32'd0);
  endtask

  task automatic wait_frame_start(input string tag);
    int k;
    k = 0;
    while (!frame_start && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(k), 32'd4);
  endtask

  // Scans one frame starting at the first clk of slot (0,0); optionally drops enable at line 1
  task automatic scan_frame(input string tag, input bit drop);
    int n_en, en_wide, addr_err, rw_err, de_err, rgb_err, hs_err, vs_err, fs_err;
    int px21, hs_low, vs_low, de_cnt, h, v, a;
    logic prev_en, e_de;
    n_en = 0; en_wide = 0; addr_err = 0; rw_err = 0; de_err = 0; rgb_err = 0;
    hs_err = 0; vs_err = 0; fs_err = 0; px21 = 0; hs_low = 0; vs_low = 0; de_cnt = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 192; c++) begin
      if (c > 0) tick();
      if (drop && c == 32) enable = 1'b0;
      h = (c / 4) % 8;
      v = c / 32;
      a = v * 4 + h;
      e_de = (h < 4) && (v < 3);
      if (fb_en) begin
        if (prev_en) en_wide++;
        if (fb_address != 17'((n_en + 1) % 12)) addr_err++;
        n_en++;
      end
      prev_en = fb_en;
      if (fb_rw) rw_err++;
      if (de !== e_de) de_err++;
      if (de) de_cnt++;
      if (e_de) begin
        if ({b, g, r} != {8'(a + 2), 8'(a + 1), 8'(a)}) rgb_err++;
      end else if ({r, g, b} != 24'd0) rgb_err++;
      if (de && r == 8'd6 && g == 8'd7 && b == 8'd8) px21++;
      if (hsync !== !(h == 5 || h == 6)) hs_err++;
      if (!hsync) hs_low++;
      if (vsync !== !(v == 4)) vs_err++;
      if (!vsync) vs_low++;
      if (frame_start !== (c == 0)) fs_err++;
    end
    check({tag, "_fb_en_pulses"}, 32'(n_en), 32'd12);
    check({tag, "_fb_en_wide"}, 32'(en_wide), 32'd0);
    check({tag, "_addr_seq_err"}, 32'(addr_err), 32'd0);
    check({tag, "_fb_rw_err"}, 32'(rw_err), 32'd0);
    check({tag, "_de_err"}, 32'(de_err), 32'd0);
    check({tag, "_de_cycles"}, 32'(de_cnt), 32'd48);
    check({tag, "_rgb_err"}, 32'(rgb_err), 32'd0);
    check({tag, "_px21_cycles"}, 32'(px21), 32'd4);
    check({tag, "_hsync_err"}, 32'(hs_err), 32'd0);
    check({tag, "_hsync_low"}, 32'(hs_low), 32'd48);
    check({tag, "_vsync_err"}, 32'(vs_err), 32'd0);
    check({tag, "_vsync_low"}, 32'(vs_low), 32'd32);
    check({tag, "_frame_start_err"}, 32'(fs_err), 32'd0);
  endtask

  initial begin
    int n_en, n_fs, n_de;
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset_outs($sformatf("reset%0d", i));
    end

    rst = 1'b0;
    tick();
    check("start_prefetch_en", 32'(fb_en), 32'd1);
    check("start_prefetch_addr", 32'(fb_address), 32'd0);
    check("start_blank_de", 32'(de), 32'd0);
    wait_frame_start("first_frame_latency");
    check("first_px_de", 32'(de), 32'd1);
    check("first_px_rgb", 32'({r, g, b}), 32'h000102);

    scan_frame("f1", 1'b0);
    tick();
    check("next_frame_start", 32'(frame_start), 32'd1);

    scan_frame("f2drop", 1'b1);
    tick();
    check_reset_outs("idle_entry");
    n_en = 0; n_fs = 0; n_de = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fb_en) n_en++;
      if (frame_start) n_fs++;
      if (de) n_de++;
    end
    check("idle_fb_en", 32'(n_en), 32'd0);
    check("idle_frame_start", 32'(n_fs), 32'd0);
    check("idle_de", 32'(n_de), 32'd0);

    enable = 1'b1;
    tick();
    check("restart_en", 32'(fb_en), 32'd1);
    check("restart_addr", 32'(fb_address), 32'd0);
    wait_frame_start("restart_latency");
    check("restart_px0_rgb", 32'({r, g, b}), 32'h000102);

    for (int i = 0; i < 5; i++) tick();
    check("px10_before_rst", 32'({de, r, g, b}), 32'h1010203);
    rst = 1'b1;
    tick();
    check_reset_outs("midpx_reset");
    rst = 1'b0;
    tick();
    check("post_rst_en", 32'(fb_en), 32'd1);
    check("post_rst_addr", 32'(fb_address), 32'd0);
    wait_frame_start("post_rst_latency");
    check("post_rst_px0_rgb", 32'({de, r, g, b}), 32'h1000102);
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_px1_rgb", 32'({de, r, g, b}), 32'h1010203);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Display scan-out stage directly downstream of the 24-bit RGB framebuffer RAM (102400 entries, 17-bit address).
- Generates raster timing and fetches one framebuffer word per active pixel in raster order, using read-only accesses.
- Delivers registered RGB, data-enable and sync to the display output pins.
- All RAM control outputs are registered in `clk`. The RAM's enable input is driven only by this block.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- H_FP, 16, horizontal front porch (pixel slots)
- H_SYNC, 48, horizontal sync width (pixel slots)
- H_BP, 16, horizontal back porch (pixel slots)
- V_ACTIVE, 320, visible lines per frame (H_ACTIVE*V_ACTIVE ≤ 102400)
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 10, vertical back porch (lines)
- PIX_DIV, 4, clk cycles per pixel slot (minimum 3)

Ports:
- clk  in  1  system clock; everything clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request; sampled only at frame boundaries
- fb_address  out  17  framebuffer read address
- fb_rw  out  1  constant 0 (read)
- fb_en  out  1  RAM access strobe; one-clk high pulse per fetch
- fb_data  in  24  RAM read data; [7:0]=R, [15:8]=G, [23:16]=B
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  high during visible pixels
- r, g, b  out  8 each  pixel colour; 0 whenever de=0
- frame_start  out  1  one-clk pulse when slot (0,0) begins

Behaviour:
- Reset: the synchronous reset drives outputs to the following values on the next edge:
  - fb_address=0, fb_en=0, hsync=1, vsync=1, de=0, r=g=b=0, frame_start=0.
  - All counters are cleared and the state goes to IDLE.
  - Reset mid-frame or mid-fetch aborts immediately; there is no partial-pixel output.
- States:
  - IDLE: outputs held at their reset values; no fetches.
  - IDLE→RUN when enable=1. The first slot is (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1), a blanking slot that prefetches pixel 0.
  - RUN→IDLE only at the end of slot (H_TOTAL-1, V_TOTAL-1) when enable=0. A mid-frame deassert therefore completes the frame.
- Counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
  - phase counts 0..PIX_DIV-1. hcnt advances on phase wrap; vcnt advances on hcnt wrap. Both wrap to 0.
- Fetch pipeline (one slot ahead):
  - During slot (h,v), the pixel for the next slot is fetched if that slot is visible.
  - phase 0: fb_address valid, fb_en=1.
  - phase 1: fb_en=0, address held.
  - phase 2: fb_data is captured into the prefetch register.
  - No fetch means fb_en stays 0 for the whole slot.
- Address:
  - A running counter increments by 1 after each fetch and resets to 0 after the last visible pixel of the frame.
  - The address sequence is therefore 0..H_ACTIVE*V_ACTIVE-1, then wraps.
  - No multiplier is used.
- Output registers load at the edge where phase wraps to 0 (start of the new slot):
  - de=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - r/g/b come from the prefetch register when de=1, otherwise 0.
  - hsync=0 iff H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync=0 iff V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC. vsync changes aligned to the hcnt=0 slot.
- All outputs are held constant for the full slot.
- frame_start is high for exactly the first clk of slot (0,0).
- Latency: each pixel's data is fetched at most PIX_DIV clk before that pixel's slot starts.

Test Plan (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, PIX_DIV=4; frame=192 clk; RAM model returns {addr+2, addr+1, addr} byte-wise):
- Reset held 5 clk, enable=1 → all outputs at reset values during reset. Exactly 4 clk after release (one prefetch slot), frame_start pulses with de=1.
- One full frame → exactly 12 fb_en pulses, each 1 clk wide. fb_address sequence 0..11, then 0 at the next frame. fb_rw=0 always.
- Pixel (x=2, y=1) → de=1 with r=6, g=7, b=8 for exactly 4 clk. In blanking slots r=g=b=0.
- Sync timing → hsync low for 8 clk per line, starting 20 clk after the line's first slot. vsync low for one 32-clk line starting at line 4.
- enable dropped at line 1 → frame completes, then state is IDLE with no further fb_en or frame_start. Re-raising enable restarts at address 0.
- rst asserted at phase 1 of pixel (1,0) → next clk outputs at reset values. After release with enable=1, the frame restarts cleanly from address 0.
